// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Hazard sequencer for the 5-stage pipeline. It produces the stall and flush
//   controls for the PC, the IF/ID bus register and the ID/EX register. It
//   handles load-use bubbles, taken-branch redirects (including the squash of
//   the fetch already in flight in the synchronous instruction ROM) and
//   fixed-latency divides that occupy EX.
//
// Ports
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   id_load_use_i      EX load's rd is read by the instruction in ID
//   ex_branch_taken_i  EX resolved a taken branch/jump this cycle
//   ex_branch_target_i target of that branch
//   ex_div_start_i     a divide entered EX this cycle
//   pc_stall_o         hold PC
//   if_id_stall_o      hold the IF/ID register
//   if_id_flush_o      load a bubble into IF/ID
//   id_ex_flush_o      load a bubble into ID/EX
//   ex_stall_o         hold EX/MEM inputs while the divider is busy
//   redirect_valid_o   load PC with redirect_pc_o
//   redirect_pc_o      redirect target (0 when no redirect)
//   stall_cnt_o        cycles in which pc_stall_o or if_id_flush_o was high
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int PCW          = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int DIV_LAT      = 33,
  parameter int CNTW         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_load_use_i,
  input  logic            ex_branch_taken_i,
  input  logic [PCW-1:0]  ex_branch_target_i,
  input  logic            ex_div_start_i,
  output logic            pc_stall_o,
  output logic            if_id_stall_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            ex_stall_o,
  output logic            redirect_valid_o,
  output logic [PCW-1:0]  redirect_pc_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam int MAXC = (FLUSH_CYCLES > DIV_LAT) ? FLUSH_CYCLES : DIV_LAT;
  localparam int CW   = $clog2(MAXC + 1);

  // Load values are clamped so that degenerate parameter values never
  // produce a negative constant; those states are simply never entered then.
  localparam int FLUSH_LOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0;
  localparam int DIV_LOAD_I   = (DIV_LAT > 2) ? DIV_LAT - 2 : 0;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_LOAD_I);
  localparam logic [CW-1:0] DIV_LOAD   = CW'(DIV_LOAD_I);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DIV   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0] stall_cnt_q;

  // State register, down-counter and performance counter. The performance
  // counter samples the same combinational controls that act on the pipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall_o || if_id_flush_o)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Next-state logic. The wait states leave when the decrement brings cnt to
  // zero, i.e. while the registered value is 1. This makes FLUSH last
  // FLUSH_CYCLES-1 cycles after the redirect cycle and DIV last DIV_LAT-2
  // cycles after the start cycle, giving a total divide stall of DIV_LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (ex_branch_taken_i) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (ex_div_start_i) begin
          if (DIV_LAT > 2) begin
            state_d = DIV;
            cnt_d   = DIV_LOAD;
          end
        end
      end
      FLUSH: begin
        if (ex_branch_taken_i) begin
          cnt_d = FLUSH_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1))
            state_d = RUN;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1))
          state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. Everything is gated by rst_ni so the controls drop the
  // moment reset is asserted, regardless of what the inputs are doing.
  // A branch is honoured in RUN and FLUSH; only DIV ignores it.
  always_comb begin
    pc_stall_o       = 1'b0;
    if_id_stall_o    = 1'b0;
    if_id_flush_o    = 1'b0;
    id_ex_flush_o    = 1'b0;
    ex_stall_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (rst_ni) begin
      case (state_q)
        RUN, FLUSH: begin
          if (ex_branch_taken_i) begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = ex_branch_target_i;
            if_id_flush_o    = 1'b1;
            id_ex_flush_o    = 1'b1;
          end else if (state_q == FLUSH) begin
            if_id_flush_o = 1'b1;
          end else if (ex_div_start_i) begin
            if (DIV_LAT > 1) begin
              pc_stall_o    = 1'b1;
              if_id_stall_o = 1'b1;
              ex_stall_o    = 1'b1;
            end
          end else if (id_load_use_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
        DIV: begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          ex_stall_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl with default parameters. Each stimulus cycle
//   pushes its hand-computed expected controls into a queue; a monitor pops
//   one entry per cycle on the falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        id_load_use_i;
  logic        ex_branch_taken_i;
  logic [31:0] ex_branch_target_i;
  logic        ex_div_start_i;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        ex_stall_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] stall_cnt_o;

  pipe_ctrl #(
    .PCW(32), .FLUSH_CYCLES(2), .DIV_LAT(33), .CNTW(32)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .id_load_use_i     (id_load_use_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_branch_target_i(ex_branch_target_i),
    .ex_div_start_i    (ex_div_start_i),
    .pc_stall_o        (pc_stall_o),
    .if_id_stall_o     (if_id_stall_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_flush_o     (id_ex_flush_o),
    .ex_stall_o        (ex_stall_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  // Flag vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall, redirect_valid}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_LU   = 6'b110100;
  localparam logic [5:0] F_BR   = 6'b001101;
  localparam logic [5:0] F_FL   = 6'b001000;
  localparam logic [5:0] F_DIV  = 6'b110010;

  typedef struct {
    logic [5:0]  flags;
    logic [31:0] rpc;
    logic [31:0] cnt;
    int          tid;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cur_tid = 0;
  int          cur_cyc = 0;
  logic [31:0] exp_cnt = 0;
  bit          stim_done = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, record what the DUT must show this cycle,
  // then advance to just after the next rising edge.
  task automatic applyStimulus(input logic lu, input logic br, input logic [31:0] tgt,
                               input logic dv, input logic [5:0] flags, input logic [31:0] rpc);
    exp_t e;
    id_load_use_i      = lu;
    ex_branch_taken_i  = br;
    ex_branch_target_i = tgt;
    ex_div_start_i     = dv;
    if (!rst_ni) exp_cnt = 0;
    e.flags = flags;
    e.rpc   = rpc;
    e.cnt   = exp_cnt;
    e.tid   = cur_tid;
    e.cyc   = cur_cyc;
    sb_q.push_back(e);
    if (rst_ni && (flags[5] || flags[3])) exp_cnt = exp_cnt + 1;
    cur_cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0] got;
    got = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, ex_stall_o, redirect_valid_o};
    tests_run++;
    if (got !== e.flags || redirect_pc_o !== e.rpc || stall_cnt_o !== e.cnt) begin
      tests_failed++;
      $display("[TB] FAIL t%0d_c%0d: got flags=%b pc=%h cnt=%0d, want flags=%b pc=%h cnt=%0d",
               e.tid, e.cyc, got, redirect_pc_o, stall_cnt_o, e.flags, e.rpc, e.cnt);
    end
  endtask

  task automatic startTest(input int tid);
    cur_tid = tid;
    cur_cyc = 0;
  endtask

  // One reset cycle with quiet inputs, then release with RUN expected.
  task automatic pulseReset();
    rst_ni = 1'b0;
    applyStimulus(0, 0, 0, 0, F_NONE, 0);
    rst_ni = 1'b1;
  endtask

  // Monitor: one expected entry is consumed every cycle.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
  end

  initial begin
    rst_ni = 1'b0;
    id_load_use_i = 0; ex_branch_taken_i = 0; ex_branch_target_i = 0; ex_div_start_i = 0;
    @(posedge clk_i);
    #1;

    // Test 1: reset held with random inputs, then quiet after release.
    startTest(1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'($urandom), F_NONE, 0);
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0, 0, F_NONE, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    // Test 2: single load-use bubble.
    startTest(2);
    applyStimulus(1, 0, 0, 0, F_LU, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    // Test 3: branch redirect; load-use/div in the flush shadow are ignored;
    // RUN again two cycles later (load-use acts there).
    startTest(3);
    pulseReset();
    applyStimulus(0, 1, 32'h0000_1040, 0, F_BR, 32'h0000_1040);
    applyStimulus(1, 0, 0, 1, F_FL, 0);
    applyStimulus(1, 0, 0, 0, F_LU, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    // Test 4: divide stalls 32 cycles; mid-wait pulses are ignored.
    startTest(4);
    pulseReset();
    applyStimulus(0, 0, 0, 1, F_DIV, 0);
    for (int i = 1; i < 32; i++)
      applyStimulus(i == 10, i == 15, 32'h0000_5555, i == 20, F_DIV, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    // Test 5: branch + div + load-use together: branch only.
    startTest(5);
    pulseReset();
    applyStimulus(1, 1, 32'h0000_2000, 1, F_BR, 32'h0000_2000);
    applyStimulus(0, 0, 0, 0, F_FL, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    // Test 5b: a second branch during FLUSH redirects again and reloads.
    startTest(6);
    applyStimulus(0, 1, 32'h0000_3000, 0, F_BR, 32'h0000_3000);
    applyStimulus(0, 1, 32'h0000_3100, 0, F_BR, 32'h0000_3100);
    applyStimulus(0, 0, 0, 0, F_FL, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    // Test 6: reset dropped at cycle 10 of a divide, then a load-use.
    startTest(7);
    pulseReset();
    applyStimulus(0, 0, 0, 1, F_DIV, 0);
    for (int i = 1; i < 10; i++)
      applyStimulus(0, 0, 0, 0, F_DIV, 0);
    rst_ni = 1'b0;
    applyStimulus(1, 0, 0, 1, F_NONE, 0);
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0, 0, F_NONE, 0);
    applyStimulus(1, 0, 0, 0, F_LU, 0);
    applyStimulus(0, 0, 0, 0, F_NONE, 0);

    stim_done = 1;
  end

  // Finish once the scoreboard drains, with a bounded wait.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_i);
    #1;
    if (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
